// File: rtl/qspi_phase_sequencer_pkg.sv
// Shared definitions for the QSPI controller: lane modes, phase codes and
// the per-mode byte timing.
package qspi_definitions;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_DUAL   = 2'd2,
    MODE_QUAD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_CS_SETUP = 3'd1,
    PH_CMD      = 3'd2,
    PH_ADDR     = 3'd3,
    PH_DUMMY    = 3'd4,
    PH_DATA     = 3'd5,
    PH_CS_HOLD  = 3'd6
  } phase_t;

  localparam logic [2:0] MAX_ADDR_BYTES = 3'd4;

  // MODE_ZERO maps to 1 so that a zero-lane phase counts single cycles.
  function automatic logic [3:0] cycles_per_byte(input logic [1:0] mode);
    case (mode)
      MODE_SINGLE: return 4'd8;
      MODE_DUAL:   return 4'd4;
      MODE_QUAD:   return 4'd2;
      default:     return 4'd1;
    endcase
  endfunction

  function automatic logic [2:0] last_cycle_index(input logic [1:0] mode);
    logic [3:0] cycles;
    cycles = cycles_per_byte(mode) - 4'd1;
    return cycles[2:0];
  endfunction

endpackage

// File: rtl/qspi_phase_counter.sv
// Cycle-in-byte and byte down-counters shared by every timed phase; neither
// counter wraps, so a phase holds at zero until the FSM reloads it.
module qspi_phase_counter #(
  parameter int DATA_LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic [2:0]            cyc_init,
  input  logic [DATA_LEN_W-1:0] byte_init,
  output logic [2:0]            cyc_cnt,
  output logic                  last
);

  logic [2:0]            cyc_reg;
  logic [DATA_LEN_W-1:0] byte_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_reg  <= 3'd0;
      byte_reg <= '0;
    end else if (load) begin
      cyc_reg  <= cyc_init;
      byte_reg <= byte_init;
    end else if (en) begin
      if (cyc_reg != 3'd0) begin
        cyc_reg <= cyc_reg - 3'd1;
      end else if (byte_reg != '0) begin
        byte_reg <= byte_reg - DATA_LEN_W'(1);
        cyc_reg  <= cyc_init;
      end
    end
  end

  assign cyc_cnt = cyc_reg;
  assign last    = (cyc_reg == 3'd0) && (byte_reg == '0);

endmodule

// File: rtl/qspi_phase_sequencer.sv
// QSPI transaction sequencer: walks one captured command descriptor through
// CS setup, command, address, dummy, data and CS hold phases.
module qspi_phase_sequencer
  import qspi_definitions::*;
#(
  parameter int DATA_LEN_W = 16,
  parameter int DUMMY_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            cmd_mode,
  input  logic [1:0]            addr_mode,
  input  logic [1:0]            data_mode,
  input  logic [2:0]            addr_bytes,
  input  logic [DUMMY_W-1:0]    dummy_cycles,
  input  logic [DATA_LEN_W-1:0] data_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sclk_en,
  output logic [2:0]            phase,
  output logic [1:0]            phase_mode,
  output logic                  byte_load
);

  phase_t                state_reg, state_next;
  logic                  done_reg;
  logic [1:0]            cmd_mode_reg, addr_mode_reg, data_mode_reg;
  logic [2:0]            addr_bytes_reg;
  logic [DUMMY_W-1:0]    dummy_reg;
  logic [DATA_LEN_W-1:0] data_bytes_reg;

  logic                  cnt_load, cnt_en, cnt_last;
  logic [2:0]            cnt_cyc, cyc_init, load_cyc, cur_cyc_init;
  logic [DATA_LEN_W-1:0] load_byte;
  logic [1:0]            cur_mode;
  logic                  en_cmd, en_addr, en_dummy, en_data;
  phase_t                after_setup, after_cmd, after_addr, after_dummy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= PH_IDLE;
      done_reg       <= 1'b0;
      cmd_mode_reg   <= 2'd0;
      addr_mode_reg  <= 2'd0;
      data_mode_reg  <= 2'd0;
      addr_bytes_reg <= 3'd0;
      dummy_reg      <= '0;
      data_bytes_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == PH_CS_HOLD);
      if (state_reg == PH_IDLE && start) begin
        cmd_mode_reg   <= cmd_mode;
        addr_mode_reg  <= addr_mode;
        data_mode_reg  <= data_mode;
        addr_bytes_reg <= (addr_bytes > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : addr_bytes;
        dummy_reg      <= dummy_cycles;
        data_bytes_reg <= data_bytes;
      end
    end
  end

  assign en_cmd   = (cmd_mode_reg != MODE_ZERO);
  assign en_addr  = (addr_mode_reg != MODE_ZERO) && (addr_bytes_reg != 3'd0);
  assign en_dummy = (dummy_reg != '0);
  assign en_data  = (data_mode_reg != MODE_ZERO) && (data_bytes_reg != '0);

  // Skip chain: each entry is the first enabled phase after the named one.
  assign after_dummy = en_data  ? PH_DATA  : PH_CS_HOLD;
  assign after_addr  = en_dummy ? PH_DUMMY : after_dummy;
  assign after_cmd   = en_addr  ? PH_ADDR  : after_addr;
  assign after_setup = en_cmd   ? PH_CMD   : after_cmd;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PH_IDLE:     if (start) state_next = PH_CS_SETUP;
      PH_CS_SETUP: state_next = abort ? PH_CS_HOLD : after_setup;
      PH_CMD:      if (abort) state_next = PH_CS_HOLD; else if (cnt_last) state_next = after_cmd;
      PH_ADDR:     if (abort) state_next = PH_CS_HOLD; else if (cnt_last) state_next = after_addr;
      PH_DUMMY:    if (abort) state_next = PH_CS_HOLD; else if (cnt_last) state_next = after_dummy;
      PH_DATA:     if (abort) state_next = PH_CS_HOLD; else if (cnt_last) state_next = PH_CS_HOLD;
      PH_CS_HOLD:  state_next = PH_IDLE;
      default:     state_next = PH_IDLE;
    endcase
  end

  // Counters are preloaded for whichever phase is entered; untimed phases get zero.
  always_comb begin
    load_cyc  = 3'd0;
    load_byte = '0;
    case (state_next)
      PH_CMD: begin
        load_cyc = last_cycle_index(cmd_mode_reg);
      end
      PH_ADDR: begin
        load_cyc  = last_cycle_index(addr_mode_reg);
        load_byte = DATA_LEN_W'(addr_bytes_reg) - DATA_LEN_W'(1);
      end
      PH_DUMMY: begin
        load_byte = DATA_LEN_W'(dummy_reg) - DATA_LEN_W'(1);
      end
      PH_DATA: begin
        load_cyc  = last_cycle_index(data_mode_reg);
        load_byte = data_bytes_reg - DATA_LEN_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_reg)
      PH_CMD:  cur_mode = cmd_mode_reg;
      PH_ADDR: cur_mode = addr_mode_reg;
      PH_DATA: cur_mode = data_mode_reg;
      default: cur_mode = MODE_ZERO;
    endcase
  end

  assign cur_cyc_init = last_cycle_index(cur_mode);
  assign cnt_load     = (state_next != state_reg);
  assign cnt_en       = (state_reg == PH_CMD) || (state_reg == PH_ADDR) ||
                        (state_reg == PH_DUMMY) || (state_reg == PH_DATA);
  assign cyc_init     = cnt_load ? load_cyc : cur_cyc_init;

  qspi_phase_counter #(
    .DATA_LEN_W(DATA_LEN_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .cyc_init (cyc_init),
    .byte_init(cnt_load ? load_byte : '0),
    .cyc_cnt  (cnt_cyc),
    .last     (cnt_last)
  );

  always_comb begin
    busy       = (state_reg != PH_IDLE);
    done       = done_reg;
    cs_n       = (state_reg == PH_IDLE);
    sclk_en    = cnt_en;
    phase      = state_reg;
    phase_mode = cur_mode;
    byte_load  = ((state_reg == PH_CMD) || (state_reg == PH_ADDR) || (state_reg == PH_DATA)) &&
                 (cnt_cyc == cur_cyc_init);
  end

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// Directed bench for qspi_phase_sequencer: cycle-by-cycle phase/strobe
// vectors for each scenario, compared against hand-computed timelines.
module tb_qspi_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  cmd_mode, addr_mode, data_mode;
  logic [2:0]  addr_bytes;
  logic [4:0]  dummy_cycles;
  logic [15:0] data_bytes;
  logic        busy, done, cs_n, sclk_en, byte_load;
  logic [2:0]  phase;
  logic [1:0]  phase_mode;

  int n_checks = 0;
  int n_fail   = 0;

  qspi_phase_sequencer #(.DATA_LEN_W(16), .DUMMY_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cmd_mode(cmd_mode), .addr_mode(addr_mode), .data_mode(data_mode),
    .addr_bytes(addr_bytes), .dummy_cycles(dummy_cycles), .data_bytes(data_bytes),
    .busy(busy), .done(done), .cs_n(cs_n), .sclk_en(sclk_en),
    .phase(phase), .phase_mode(phase_mode), .byte_load(byte_load)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [1:0] c, input logic [1:0] a, input logic [1:0] d,
                          input logic [2:0] ab, input logic [4:0] dc, input logic [15:0] db);
    cmd_mode = c; addr_mode = a; data_mode = d;
    addr_bytes = ab; dummy_cycles = dc; data_bytes = db;
  endtask

  // {phase, phase_mode, byte_load, done, cs_n, sclk_en, busy}
  function automatic logic [9:0] pack_exp(input int ph, input int md, input bit bl, input bit dn);
    logic [2:0] p;
    logic [1:0] m;
    p = ph[2:0];
    m = md[1:0];
    return {p, m, bl, dn, (ph == 0), (ph >= 2 && ph <= 5), (ph != 0)};
  endfunction

  function automatic logic [9:0] pack_act();
    return {phase, phase_mode, byte_load, done, cs_n, sclk_en, busy};
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    set_desc(0, 0, 0, 0, 0, 0);
    tick; tick;
    n_checks++;
    if (pack_act() !== pack_exp(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", pack_act(), pack_exp(0, 0, 0, 0));
    end
    reset = 1'b0;
    tick;
    n_checks++;
    if (pack_act() !== pack_exp(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required %b", pack_act(), pack_exp(0, 0, 0, 0));
    end
    $display("txn reset: done");
  endtask

  task automatic test_full_txn;
    int ph, md;
    bit bl;
    set_desc(1, 3, 3, 3, 8, 4);
    start = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick;
      if (k == 1) begin
        start = 1'b0;
        set_desc(2, 1, 1, 2, 3, 9);
      end
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      ph = (k == 1) ? 1 : (k <= 9) ? 2 : (k <= 15) ? 3 : (k <= 23) ? 4 :
           (k <= 31) ? 5 : (k == 32) ? 6 : 0;
      md = (ph == 2) ? 1 : (ph == 3 || ph == 5) ? 3 : 0;
      bl = (k == 2 || k == 10 || k == 12 || k == 14 || k == 24 || k == 26 || k == 28 || k == 30);
      n_checks++;
      if (pack_act() !== pack_exp(ph, md, bl, k == 33)) begin
        n_fail++;
        $display("FAIL full_cycle_%0d: got %b required %b", k, pack_act(), pack_exp(ph, md, bl, k == 33));
      end
    end
    $display("txn full: cmd single, addr 3 quad, dummy 8, data 4 quad");
  endtask

  task automatic test_all_disabled;
    int exp_ph [4] = '{1, 6, 0, 0};
    set_desc(0, 2, 1, 0, 0, 0);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      start = 1'b0;
      n_checks++;
      if (pack_act() !== pack_exp(exp_ph[k-1], 0, 0, k == 3)) begin
        n_fail++;
        $display("FAIL disabled_cycle_%0d: got %b required %b", k, pack_act(), pack_exp(exp_ph[k-1], 0, 0, k == 3));
      end
    end
    $display("txn all phases disabled");
  endtask

  task automatic test_addr_clamp;
    int ph, n_addr, n_load;
    n_addr = 0; n_load = 0;
    set_desc(0, 2, 0, 7, 0, 0);
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      start = 1'b0;
      if (phase == 3'd3) n_addr++;
      if (byte_load) n_load++;
      ph = (k == 1) ? 1 : (k <= 17) ? 3 : (k == 18) ? 6 : 0;
      n_checks++;
      if (pack_act() !== pack_exp(ph, (ph == 3) ? 2 : 0,
                                  (k == 2 || k == 6 || k == 10 || k == 14), k == 19)) begin
        n_fail++;
        $display("FAIL clamp_cycle_%0d: got %b", k, pack_act());
      end
    end
    n_checks++;
    if (n_addr !== 16 || n_load !== 4) begin
      n_fail++;
      $display("FAIL clamp_totals: addr cycles %0d loads %0d required 16 and 4", n_addr, n_load);
    end
    $display("txn addr_bytes=7 dual");
  endtask

  task automatic test_abort;
    int ph;
    set_desc(0, 0, 1, 0, 0, 5);
    start = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick;
      start = 1'b0;
      abort = (k == 20 || k == 23);
      ph = (k == 1) ? 1 : (k <= 20) ? 5 : (k == 21) ? 6 : 0;
      n_checks++;
      if (pack_act() !== pack_exp(ph, (ph == 5) ? 1 : 0,
                                  (k == 2 || k == 10 || k == 18), k == 22)) begin
        n_fail++;
        $display("FAIL abort_cycle_%0d: got %b required %b", k, pack_act(),
                 pack_exp(ph, (ph == 5) ? 1 : 0, (k == 2 || k == 10 || k == 18), k == 22));
      end
    end
    abort = 1'b0;
    tick;
    n_checks++;
    if (pack_act() !== pack_exp(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_in_idle: got %b", pack_act());
    end
    $display("txn abort in 3rd data byte");
  endtask

  task automatic test_back_to_back;
    int exp_ph [10] = '{1, 6, 0, 1, 2, 2, 6, 0, 0, 0};
    int ph;
    set_desc(0, 0, 0, 0, 0, 0);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      start = 1'b0;
      if (k == 3) begin
        start = 1'b1;
        set_desc(3, 0, 0, 0, 0, 0);
      end
      if (k == 5) begin
        start = 1'b1;
        set_desc(1, 1, 1, 4, 20, 100);
      end
      ph = exp_ph[k-1];
      n_checks++;
      if (pack_act() !== pack_exp(ph, (ph == 2) ? 3 : 0, k == 5, k == 3 || k == 8)) begin
        n_fail++;
        $display("FAIL b2b_cycle_%0d: got %b required %b", k, pack_act(),
                 pack_exp(ph, (ph == 2) ? 3 : 0, k == 5, k == 3 || k == 8));
      end
    end
    $display("txn back-to-back with ignored busy start");
  endtask

  task automatic test_reset_mid;
    set_desc(1, 3, 3, 3, 8, 4);
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick;
      start = 1'b0;
    end
    n_checks++;
    if (phase !== 3'd4) begin
      n_fail++;
      $display("FAIL pre_reset_phase: got %0d required 4", phase);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (pack_act() !== pack_exp(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", pack_act(), pack_exp(0, 0, 0, 0));
    end
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++;
      if (pack_act() !== pack_exp(0, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL post_reset_%0d: got %b required idle, no done", k, pack_act());
      end
    end
    $display("txn reset during dummy");
  endtask

  initial begin
    test_reset;
    test_full_txn;
    test_all_disabled;
    test_addr_clamp;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_phase_sequencer.md
# qspi_phase_sequencer

Transaction sequencer for the QSPI controller: accepts one flash command descriptor and walks it through the phases chip-select setup, command, address, dummy, data and chip-select hold. Each phase has its own lane mode. The block drives the phase/mode selection for the shift datapath, requests bytes from the shifter, gates SCLK, owns CS_n, and reports completion to the register front-end. It sits between the QSPI register block and the shift-register/lane datapath.

## Interface
Parameters:
- `DATA_LEN_W`, 16: width of the data byte count.
- `DUMMY_W`, 5: width of the dummy-cycle count.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request. Accepted only in IDLE; ignored otherwise.
- `abort`  in  1  terminates the current transaction early; ignored in IDLE.
- `cmd_mode`  in  2  lane mode for the command phase.
- `addr_mode`  in  2  lane mode for the address phase.
- `data_mode`  in  2  lane mode for the data phase.
- `addr_bytes`  in  3  address length, 0..4. Values 5..7 are clamped to 4.
- `dummy_cycles`  in  DUMMY_W  number of dummy SCLK cycles.
- `data_bytes`  in  DATA_LEN_W  number of data bytes; 0 means no data phase.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `cs_n`  out  1  flash chip select, active low.
- `sclk_en`  out  1  SCLK gate; high only during the CMD, ADDR, DUMMY and DATA phases.
- `phase`  out  3  current phase code.
- `phase_mode`  out  2  lane mode of the current phase. Reads MODE_ZERO outside CMD/ADDR/DATA.
- `byte_load`  out  1  pulse on the first cycle of every byte in CMD, ADDR and DATA.

## Operation
- Mode encoding: MODE_ZERO=0, SINGLE=1, DUAL=2, QUAD=3.
- Cycles per byte by mode: SINGLE 8, DUAL 4, QUAD 2.
- State machine states: IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD.
- On an accepted `start`, all descriptor inputs are registered. Later input changes have no effect until the next accepted `start`.
- Transition IDLE→CS_SETUP. CS_SETUP lasts 1 cycle with `cs_n`=0 and `sclk_en`=0.
- The FSM then enters the next enabled phase in the fixed order CMD, ADDR, DUMMY, DATA. A phase is skipped when:
  - CMD: `cmd_mode`=ZERO.
  - ADDR: `addr_mode`=ZERO or `addr_bytes`=0.
  - DUMMY: `dummy_cycles`=0.
  - DATA: `data_mode`=ZERO or `data_bytes`=0.
- Phase durations:
  - CMD: exactly 1 byte.
  - ADDR: `addr_bytes` bytes.
  - DUMMY: `dummy_cycles` cycles, reported with `phase_mode`=ZERO.
  - DATA: `data_bytes` bytes.
- After the last enabled phase, or straight from CS_SETUP if no phase is enabled, the FSM enters CS_HOLD for 1 cycle with `cs_n`=0 and `sclk_en`=0. It then returns to IDLE.
- In the first IDLE cycle after CS_HOLD: `done`=1 and `cs_n`=1.
- A `start` asserted in that same cycle is accepted, so back-to-back transactions are allowed with a minimum CS_n-high time of 1 cycle.
- `abort` in CS_SETUP, CMD, ADDR, DUMMY or DATA: next state is CS_HOLD, then IDLE with `done`. `abort` in CS_HOLD has no extra effect.
- Counters:
  - A cycle-in-byte down-counter, 3 bits.
  - A byte down-counter, DATA_LEN_W bits, loaded at phase entry.
  - The byte counter is reused for dummy cycles.
  - No counter ever wraps: a phase exits on the cycle its final count is reached.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `cs_n`=1, `sclk_en`=0, `phase`=IDLE code, `phase_mode`=ZERO, `byte_load`=0, all counters 0.
- Reset asserted mid-transaction returns to IDLE immediately, with no `done` pulse.
- All outputs are registered, decoded from the current state and counters.
- Latency from `start` to `busy`=1 is 1 cycle.
- Total busy cycles = 1 + 8/W(cmd) + addr_bytes·8/W(addr) + dummy + data_bytes·8/W(data) + 1, where each term is counted only if its phase is enabled and W is the number of lanes for that phase's mode (8/W = cycles per byte).
- `done` follows 1 cycle after the last busy cycle.

## Structure
- Shared package `qspi_definitions`:
  - mode encodings;
  - phase codes IDLE=0, CS_SETUP=1, CMD=2, ADDR=3, DUMMY=4, DATA=5, CS_HOLD=6;
  - a cycles-per-byte function of mode.
- One natural sub-module, `qspi_phase_counter`: cycle-in-byte and byte counters with load, decrement and `last` outputs.
- The FSM stays in the top module.

## Test plan
- Command SINGLE, address 3 bytes QUAD, 8 dummy cycles, 4 data bytes QUAD, `start` at cycle 0 -> CMD cycles 2–9, ADDR 10–15, DUMMY 16–23, DATA 24–31, CS_HOLD 32, `done` at 33; `byte_load` pulses at 2, 10, 12, 14, 24, 26, 28, 30.
- All phases disabled -> CS_SETUP at 1, CS_HOLD at 2, `done` at 3, `sclk_en` never high.
- `addr_bytes`=7 with DUAL address -> 4 bytes, 16 ADDR cycles.
- `abort` during the 3rd DATA byte -> CS_HOLD next cycle, `done` 1 cycle later, `cs_n`=1.
- `start` in the `done` cycle, plus `start` pulsed while busy -> the first is accepted (CS_SETUP next cycle); the second is ignored (no descriptor change).
- `reset` asserted in DUMMY -> IDLE immediately, `cs_n`=1, no `done`.
